// File: rtl/button_event_unit_pkg.sv
// Shared definitions for the button event unit: event codes and the I/O address
// at which the CPU drains the event FIFO.
package button_event_unit_pkg;

   localparam logic [7:0] EVT_NONE    = 8'h00;
   localparam logic [7:0] EVT_CW      = 8'h01;
   localparam logic [7:0] EVT_ACW     = 8'h02;
   localparam logic [7:0] EVT_BOTH    = 8'h03;
   localparam logic [7:0] IO_ADDR_BTN = 8'h01;

   // Bit 0 = clockwise press, bit 1 = anticlockwise press; both at once maps to EVT_BOTH.
   function automatic logic [7:0] evt_encode(input logic cw, input logic acw);
      return {6'b000000, acw, cw};
   endfunction

endpackage

// File: rtl/button_event_unit_debounce.sv
// Two-flop synchroniser plus counter debouncer for one raw button, producing a
// single-cycle pulse on the edge where the debounced level flips 0->1.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn,
   output logic o_rise
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_diff;
   logic          w_flip;

   assign w_diff = r_sync2 ^ r_level;
   // The flip happens on the edge where the counter would reach DEBOUNCE_CYCLES.
   assign w_flip = w_diff && (r_cnt == LAST);
   assign o_rise = w_flip & ~r_level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_flip) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/button_event_unit.sv
// Debounces the rotary buttons, queues press events for the CPU and tracks a
// wrapping position count.
module button_event_unit
   import button_event_unit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bc,
   input  logic       bac,
   input  logic       io_rd,
   output logic [7:0] io_data,
   output logic       event_valid,
   output logic       overflow,
   input  logic       ovf_clr,
   output logic [7:0] position
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int NW = AW + 1;

   logic [1:0]    w_btn;
   logic [1:0]    w_rise;
   logic [7:0]    w_code;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_wr;
   logic          w_drop;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [NW-1:0] r_count;
   logic          r_overflow;
   logic [7:0]    r_position;

   assign w_btn = {bac, bc};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_btn
         button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .i_btn (w_btn[gi]),
            .o_rise(w_rise[gi])
         );
      end
   endgenerate

   assign w_code  = evt_encode(w_rise[0], w_rise[1]);
   assign w_push  = (w_code != EVT_NONE);
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == NW'(FIFO_DEPTH));
   assign w_pop   = io_rd & ~w_empty;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_code;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_position <= 8'h00;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + NW'(1);
            2'b01:   r_count <= r_count - NW'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end
         // Position follows every decoded press, including ones the FIFO drops.
         if (w_code == EVT_CW) begin
            r_position <= r_position + 8'h01;
         end else if (w_code == EVT_ACW) begin
            r_position <= r_position - 8'h01;
         end
      end
   end

   assign io_data     = w_empty ? EVT_NONE : r_mem[r_rd_ptr];
   assign event_valid = ~w_empty;
   assign overflow    = r_overflow;
   assign position    = r_position;

endmodule
